period_meter: RTL and testbench



---
 rtl/period_meter_pkg.sv | 21 ++
 rtl/period_meter_sync_edge_detect.sv | 47 ++++
 rtl/period_meter.sv | 120 ++++++++++++
 tb/tb_period_meter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : period_meter_pkg
// Desc     : Shared state encoding and default sizes for the period meter.
// Revision : 1.0 - initial release
// ============================================================================
package period_meter_pkg;

  localparam int unsigned c_cnt_width_def   = 32;
  localparam int unsigned c_sync_stages_def = 2;
  localparam int unsigned c_timeout_def     = 50_000_000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_COUNT = 2'd2,
    S_STUCK = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/period_meter_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Desc     : Multi-stage synchronizer for an asynchronous input followed by a
//            registered rising-edge detector. Rise is a one-cycle pulse,
//            SYNC_STAGES+1 cycles after the input rises.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect
  import period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = c_sync_stages_def
) (
  input  logic Clk,
  input  logic nReset,
  input  logic D,
  output logic Rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   r_rise;

  // Synchronizer chain; the input enters at bit 0 and leaves at the MSB.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], D};
    end
  end

  // Delayed copy of the synchronized level and registered rising-edge pulse.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_dly  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_dly  <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_dly;
    end
  end

  assign Rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// Module   : period_meter
// Desc     : Measures the period of a slow asynchronous square wave in Clk
//            cycles, strobes each new result, range-checks it and flags an
//            input that has stopped toggling.
// Revision : 1.0 - initial release
// ============================================================================
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = c_cnt_width_def,
  parameter int unsigned TIMEOUT     = c_timeout_def,
  parameter int unsigned SYNC_STAGES = c_sync_stages_def
) (
  input  logic                 Clk,
  input  logic                 nReset,
  input  logic                 Enable,
  input  logic                 Sig_in,
  input  logic [CNT_WIDTH-1:0] Min_period,
  input  logic [CNT_WIDTH-1:0] Max_period,
  output logic [CNT_WIDTH-1:0] Period,
  output logic                 Period_valid,
  output logic                 Freq_ok,
  output logic                 Stuck
);

  localparam logic [CNT_WIDTH-1:0] c_timeout = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] c_one     = CNT_WIDTH'(1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_edge;
  logic                 w_in_range;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .Clk    (Clk),
    .nReset (nReset),
    .D      (Sig_in),
    .Rise   (w_edge)
  );

  // Inclusive unsigned window; an inverted window can never be satisfied.
  assign w_in_range = (r_cnt >= Min_period) && (r_cnt <= Max_period);

  // Measurement FSM with counter and registered outputs. The counter is also
  // used as the timeout timer while waiting for the first edge, so it is
  // loaded with 1 on entry and compared against the same limit.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      Period       <= '0;
      Period_valid <= 1'b0;
      Freq_ok      <= 1'b0;
      Stuck        <= 1'b0;
    end else begin
      Period_valid <= 1'b0;
      if (!Enable) begin
        // Disable wins over any edge in the same cycle; Period is kept.
        r_state <= S_IDLE;
        r_cnt   <= '0;
        Freq_ok <= 1'b0;
        Stuck   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_FIRST;
            r_cnt   <= c_one;
          end
          S_FIRST: begin
            if (w_edge) begin
              r_state <= S_COUNT;
              r_cnt   <= c_one;
            end else if (r_cnt == c_timeout) begin
              r_state <= S_STUCK;
              Stuck   <= 1'b1;
              Freq_ok <= 1'b0;
            end else begin
              r_cnt <= r_cnt + c_one;
            end
          end
          S_COUNT: begin
            // An edge arriving exactly at the timeout still counts.
            if (w_edge) begin
              Period       <= r_cnt;
              Period_valid <= 1'b1;
              Freq_ok      <= w_in_range;
              Stuck        <= 1'b0;
              r_cnt        <= c_one;
            end else if (r_cnt == c_timeout) begin
              r_state <= S_STUCK;
              Stuck   <= 1'b1;
              Freq_ok <= 1'b0;
            end else begin
              r_cnt <= r_cnt + c_one;
            end
          end
          S_STUCK: begin
            // Stuck stays set until a full period has been measured again.
            Stuck   <= 1'b1;
            Freq_ok <= 1'b0;
            if (w_edge) begin
              r_state <= S_COUNT;
              r_cnt   <= c_one;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_period_meter
// Desc     : Randomized self-checking bench for period_meter. Sig_in is driven
//            synchronously to Clk; the reference model works on cycle numbers
//            of input rises and the documented latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_period_meter;

  localparam int c_to   = 64;
  localparam int c_lat  = 4;          // Sig_in rise to result, SYNC_STAGES+2
  localparam int c_maxc = 30000;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        Enable = 1'b0;
  logic        Sig_in = 1'b0;
  logic [31:0] Min_period = 32'd8;
  logic [31:0] Max_period = 32'd12;
  logic [31:0] Period;
  logic        Period_valid;
  logic        Freq_ok;
  logic        Stuck;

  period_meter #(
    .CNT_WIDTH   (32),
    .TIMEOUT     (c_to),
    .SYNC_STAGES (2)
  ) dut (
    .Clk          (Clk),
    .nReset       (nReset),
    .Enable       (Enable),
    .Sig_in       (Sig_in),
    .Min_period   (Min_period),
    .Max_period   (Max_period),
    .Period       (Period),
    .Period_valid (Period_valid),
    .Freq_ok      (Freq_ok),
    .Stuck        (Stuck)
  );

  always #5 Clk = ~Clk;

  // Per-cycle history of what was driven.
  bit sig_h [c_maxc];
  bit en_h  [c_maxc];
  bit rst_h [c_maxc];
  int cyc      = 0;
  int last_rst = -1;
  bit prev_rn  = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit          m_active;    // enabled and running
  bit          m_ref_ok;    // a reference rise exists, next rise is a measurement
  bit          m_halted;    // timeout reached, waiting for input to resume
  int          m_ref;       // cycle of the reference rise (or of enable entry)
  bit          m_stuck, m_ok, m_valid;
  logic [31:0] m_period;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_period"}, Period, m_period);
    chk({tag, "_valid"}, {31'd0, Period_valid}, {31'd0, m_valid});
    chk({tag, "_freq_ok"}, {31'd0, Freq_ok}, {31'd0, m_ok});
    chk({tag, "_stuck"}, {31'd0, Stuck}, {31'd0, m_stuck});
  endtask

  function automatic void model_reset();
    m_active = 1'b0; m_ref_ok = 1'b0; m_halted = 1'b0; m_ref = 0;
    m_stuck  = 1'b0; m_ok     = 1'b0; m_valid  = 1'b0; m_period = '0;
  endfunction

  // A rise of the driven input in cycle t (the synchronizer restarts from 0
  // after reset, so a high level right after release is a rise).
  function automatic bit rise_at(input int t);
    bit prev;
    prev = (t > 0) && !rst_h[t-1] && sig_h[t-1];
    return sig_h[t] && !rst_h[t] && !prev;
  endfunction

  // Expected behaviour at clock edge e: inputs driven in cycle e-1 are seen
  // here, and a rise driven in cycle e-c_lat is acted upon here unless a
  // reset intervened.
  function automatic void model_edge(input int e);
    int c;
    int t;
    bit r;
    c = e - 1;
    t = e - c_lat;
    if (rst_h[c]) begin
      model_reset();
      return;
    end
    r = (t >= 0) && (t > last_rst) && rise_at(t);
    m_valid = 1'b0;
    if (!en_h[c]) begin
      m_active = 1'b0; m_stuck = 1'b0; m_ok = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1; m_ref_ok = 1'b0; m_halted = 1'b0; m_ref = e;
    end else if (r) begin
      if (m_ref_ok) begin
        m_period = 32'(e - m_ref);
        m_valid  = 1'b1;
        m_ok     = (m_period >= Min_period) && (m_period <= Max_period);
        m_stuck  = 1'b0;
      end
      m_ref_ok = 1'b1; m_halted = 1'b0; m_ref = e;
    end else if (!m_halted && (e - m_ref == c_to)) begin
      m_halted = 1'b1; m_ref_ok = 1'b0; m_stuck = 1'b1; m_ok = 1'b0;
    end
  endfunction

  // One clock cycle of stimulus followed by a full output check.
  task automatic step(input bit s, input bit en, input bit rn);
    int c;
    c = cyc;
    Sig_in = s; Enable = en; nReset = rn;
    sig_h[c] = s; en_h[c] = en; rst_h[c] = !rn;
    if (!rn) begin
      last_rst = c;
      if (prev_rn) begin
        model_reset();
        #1;
        check_all("rst_async");
      end
    end
    prev_rn = rn;
    @(posedge Clk);
    model_edge(c + 1);
    #1;
    check_all("cyc");
    cyc++;
    if (cyc >= c_maxc) begin
      $display("FAIL cycle_budget got=%0d exp<%0d", cyc, c_maxc);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic wave(input int hi, input int lo, input int n, input bit en);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) step(1'b1, en, 1'b1);
      for (int i = 0; i < lo; i++) step(1'b0, en, 1'b1);
    end
  endtask

  task automatic hold_low(input int n, input bit en);
    for (int i = 0; i < n; i++) step(1'b0, en, 1'b1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    // Reset held for 100 ns while the input toggles.
    for (int i = 0; i < 10; i++) step(1'(i % 2), 1'b1, 1'b0);
    hold_low(3, 1'b1);

    // Steady period 10, in range 8..12.
    Min_period = 32'd8; Max_period = 32'd12;
    wave(5, 5, 8, 1'b1);
    // Period 14 out of range, then 12 on the inclusive bound.
    wave(7, 7, 4, 1'b1);
    wave(6, 6, 4, 1'b1);

    // Timeout after the input stops, then recovery at period 10.
    hold_low(80, 1'b1);
    wave(5, 5, 5, 1'b1);

    // Edge exactly at the timeout, then one cycle beyond it.
    Min_period = 32'd60; Max_period = 32'd64;
    wave(32, 32, 3, 1'b1);
    wave(33, 32, 3, 1'b1);

    // Reset mid-period, then re-acquire.
    Min_period = 32'd8; Max_period = 32'd12;
    wave(5, 5, 3, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    do_reset(5);
    hold_low(3, 1'b1);
    wave(5, 5, 4, 1'b1);

    // Enable dropped mid-period: Period must be retained.
    wave(5, 5, 3, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    wave(1, 1, 3, 1'b0);
    hold_low(2, 1'b1);
    wave(5, 5, 4, 1'b1);

    // Divider loopback: toggle every N cycles, exact window at 2N.
    for (int n = 2; n <= 5; n++) begin
      Min_period = 32'(2 * n); Max_period = 32'(2 * n);
      wave(n, n, 6, 1'b1);
    end

    // Randomized segments.
    for (int k = 0; k < 40; k++) begin
      int sel;
      Min_period = 32'($urandom_range(2, 40));
      Max_period = 32'($urandom_range(2, 40));
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        do_reset($urandom_range(1, 6));
      end else if (sel == 1) begin
        wave($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3), 1'b0);
      end else if (sel == 2) begin
        hold_low($urandom_range(55, 90), 1'b1);
      end
      wave($urandom_range(2, 20), $urandom_range(2, 20), $urandom_range(1, 4), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
